// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory read port and the fetch->decode
// valid/ready handshake of fetch_unit.
//   mem_addr  : fetch unit -> memory, read address (equals pc)
//   mem_instr : memory -> fetch unit, combinational read data
//   out_valid : fetch unit -> decoder, out_instr/out_pc hold a valid instruction
//   out_ready : decoder -> fetch unit, decoder accepts this cycle
//   out_instr : fetch unit -> decoder, registered instruction
//   out_pc    : fetch unit -> decoder, address out_instr was fetched from
interface fetch_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output mem_addr,
        input  mem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  mem_addr,
        output mem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational-read
// instruction memory. Owns the program counter, captures the fetched word
// into a fetch/decode register and offers it through a valid/ready handshake.
// Supports start, stall (fetch_en low), backpressure, redirect with flush.
//
// Optional feature macro: FETCH_HALT_EN -- when defined, loading HALT_OPCODE
// delivers that word and then parks the unit in HALT until a redirect.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : pulse, leaves IDLE
//   fetch_en        : stall when low in RUN
//   redirect_valid  : branch/jump taken; redirect_addr is the new pc
//   bus (master)    : memory address/data and decoder handshake (fetch_if)
//   pc              : current program counter
//   halted          : high while in HALT
module fetch_unit #(
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_W-1:0]  HALT_OPCODE = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    fetch_if.master           bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic               load;
    logic               fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        fire = out_valid_q & bus.out_ready;
        // A slot is free when the register is empty or being drained this cycle.
        load = (state_q == RUN) & fetch_en & ~redirect_valid
               & (~out_valid_q | bus.out_ready);

        if (redirect_valid) begin
            // Redirect wins over everything, flushing even an accepted word.
            pc_d        = redirect_addr;
            out_valid_d = 1'b0;
            if (state_q == HALT) begin
                state_d = RUN;
            end
        end else begin
            if ((state_q == IDLE) && start) begin
                state_d = RUN;
            end
            if (load) begin
                out_instr_d = bus.mem_instr;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + 1'b1;
`ifdef FETCH_HALT_EN
                if (bus.mem_instr == HALT_OPCODE) begin
                    state_d = HALT;
                end
`endif
            end else if (fire) begin
                out_valid_d = 1'b0;
            end
        end
    end

    assign bus.mem_addr  = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign pc            = pc_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps followed by randomized traffic,
// checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fetch_en;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic [7:0] pc;
    logic       halted;

    logic [15:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_mode;   // 0 idle, 1 run, 2 halt
    int          m_pc;
    bit          m_v;
    logic [15:0] m_instr;
    int          m_opc;

    fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    assign bus.mem_instr = mem[bus.mem_addr];

    fetch_unit #(
        .ADDR_W(8),
        .INSTR_W(16),
        .RESET_PC(8'h00),
        .HALT_OPCODE(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .bus(bus),
        .pc(pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_v     = 0;
        m_instr = 16'h0000;
        m_opc   = 0;
    endtask

    task automatic check_all();
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_v});
        check("out_instr", {16'd0, bus.out_instr}, {16'd0, m_instr});
        check("out_pc",    {24'd0, bus.out_pc},    m_opc);
        check("pc",        {24'd0, pc},            m_pc);
        check("mem_addr",  {24'd0, bus.mem_addr},  m_pc);
`ifdef FETCH_HALT_EN
        check("halted",    {31'd0, halted},        (m_mode == 2) ? 1 : 0);
`else
        check("halted",    {31'd0, halted},        0);
`endif
    endtask

    // Advance the model by one edge using the inputs applied now, then
    // let the DUT take the same edge and compare everything.
    task automatic cycle();
        bit ld;
        if (redirect_valid) begin
            m_pc = redirect_addr;
            m_v  = 0;
            if (m_mode == 2) m_mode = 1;
        end else begin
            ld = (m_mode == 1) && fetch_en && (!m_v || bus.out_ready);
            if (m_mode == 0 && start) m_mode = 1;
            if (ld) begin
                m_instr = mem[m_pc];
                m_opc   = m_pc;
                m_v     = 1;
                m_pc    = (m_pc + 1) % 256;
`ifdef FETCH_HALT_EN
                if (m_instr == 16'hFFFF) m_mode = 2;
`endif
            end else if (m_v && bus.out_ready) begin
                m_v = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        bus.out_ready  = 1'b1;
    endtask

    task automatic redirect_to(input logic [7:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: start and stream
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("t1_no_valid_1edge", {31'd0, bus.out_valid}, 0);
        cycle();
        check("t1_out_pc0",  {24'd0, bus.out_pc}, 0);
        check("t1_instr0",   {16'd0, bus.out_instr}, 32'h1000);
        cycle();
        check("t1_instr1",   {16'd0, bus.out_instr}, 32'h1001);
        cycle();
        check("t1_out_pc2",  {24'd0, bus.out_pc}, 2);

        // 2: backpressure while out_pc=2 is valid
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_held_instr", {16'd0, bus.out_instr}, 32'h1002);
            check("t2_held_pc",    {24'd0, pc}, 3);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("t2_next_pc3", {24'd0, bus.out_pc}, 3);

        // 3: redirect with a live, accepted word
        redirect_to(8'h40);
        check("t3_flush", {31'd0, bus.out_valid}, 0);
        cycle();
        check("t3_target_pc",    {24'd0, bus.out_pc}, 32'h40);
        check("t3_target_instr", {16'd0, bus.out_instr}, 32'h1040);

        // 4: wrap at top of address space
        redirect_to(8'hFE);
        cycle();
        check("t4_fe", {24'd0, bus.out_pc}, 32'hFE);
        cycle();
        check("t4_ff", {24'd0, bus.out_pc}, 32'hFF);
        cycle();
        check("t4_00", {24'd0, bus.out_pc}, 32'h00);
        check("t4_pc01", {24'd0, pc}, 1);

        // 5: halt opcode
        mem[3] = 16'hFFFF;
        redirect_to(8'h00);
        for (int i = 0; i < 4; i++) cycle();
        check("t5_halt_pc",    {24'd0, bus.out_pc}, 3);
        check("t5_halt_instr", {16'd0, bus.out_instr}, 32'hFFFF);
`ifdef FETCH_HALT_EN
        check("t5_halted", {31'd0, halted}, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t5_no_valid", {31'd0, bus.out_valid}, 0);
        end
        redirect_to(8'h10);
        check("t5_unhalted", {31'd0, halted}, 0);
        cycle();
        check("t5_resume_pc", {24'd0, bus.out_pc}, 32'h10);
`else
        cycle();
        check("t5_direct_pc4", {24'd0, bus.out_pc}, 4);
`endif
        mem[3] = 16'h1003;

        // 6: asynchronous reset between edges
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_valid", {31'd0, bus.out_valid}, 0);
        check("t6_pc",    {24'd0, pc}, 0);
        check("t6_instr", {16'd0, bus.out_instr}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("t6_idle_pc", {24'd0, pc}, 0);

        // Randomized traffic
        for (int k = 0; k < 256; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            mem[k] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : w;
        end
        for (int n = 0; n < 600; n++) begin
            start          = ($urandom_range(0, 9) == 0);
            fetch_en       = ($urandom_range(0, 3) != 0);
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_addr  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
